// File: rtl/enemy_spawn_pkg.sv
// Shared types and constants for the enemy spawn controller: FSM states,
// spawn-point coordinate table and the slot-to-coordinate lookup.
package enemy_spawn_pkg;

    localparam int unsigned COORD_W     = 11;
    localparam int unsigned TIMER_W     = 8;
    localparam int unsigned TABLE_SLOTS = 4;
    localparam int unsigned SLOT_IDX_W  = 2;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        REQ,
        SAMPLE,
        CHECK,
        OFFER,
        DONE
    } spawn_state_t;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } spawn_coord_t;

    localparam logic [COORD_W-1:0] SLOT_X [TABLE_SLOTS] = '{11'd32, 11'd192, 11'd352, 11'd512};
    localparam logic [COORD_W-1:0] SLOT_Y [TABLE_SLOTS] = '{11'd32, 11'd32, 11'd32, 11'd32};

    // Top-left corner of a spawn point.
    function automatic spawn_coord_t slot_coord(input logic [SLOT_IDX_W-1:0] idx);
        spawn_coord_t c;
        c.x = SLOT_X[idx];
        c.y = SLOT_Y[idx];
        return c;
    endfunction

endpackage

// File: rtl/enemy_spawn_ctrl_timer.sv
// Loadable frame-counted down-timer; decrements on frame pulses and
// saturates at zero. The zero flag is registered alongside the count.
module frame_down_timer
    import enemy_spawn_pkg::*;
(
    input  logic               clk,
    input  logic               resetN,
    input  logic               load,
    input  logic [TIMER_W-1:0] load_value,
    input  logic               dec,
    output logic               zero
);

    logic [TIMER_W-1:0] count;
    logic [TIMER_W-1:0] count_n;

    always_comb begin
        count_n = count;
        if (load) begin
            count_n = load_value;
        end else if (dec && (count != '0)) begin
            count_n = count - TIMER_W'(1);
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            count <= '0;
            zero  <= 1'b1;
        end else begin
            count <= count_n;
            zero  <= (count_n == '0);
        end
    end

endmodule

// File: rtl/enemy_spawn_ctrl.sv
// Enemy spawn controller: paces spawn attempts by frames, asks the random
// generator for a slot, skips blocked slots and offers the spawn to the pool.
module enemy_spawn_ctrl
    import enemy_spawn_pkg::*;
#(
    parameter int unsigned SPAWN_PERIOD  = 120,
    parameter int unsigned RETRY_FRAMES  = 8,
    parameter int unsigned TOTAL_ENEMIES = 20,
    parameter int unsigned MAX_ALIVE     = 4,
    parameter int unsigned NUM_SLOTS     = 4,
    parameter int unsigned SLOT_BITS     = 2
)(
    input  logic                 clk,
    input  logic                 resetN,
    input  logic                 game_enable,
    input  logic                 startOfFrame,
    input  logic [SLOT_BITS-1:0] rand_slot,
    input  logic [NUM_SLOTS-1:0] slot_blocked,
    input  logic                 enemy_destroyed,
    input  logic                 spawn_ready,
    output logic                 rand_rise,
    output logic                 spawn_valid,
    output logic [SLOT_BITS-1:0] spawn_slot,
    output logic [COORD_W-1:0]   spawn_x,
    output logic [COORD_W-1:0]   spawn_y,
    output logic [4:0]           enemies_left,
    output logic [2:0]           alive_cnt,
    output logic                 level_cleared
);

    localparam int unsigned LEFT_W  = 5;
    localparam int unsigned ALIVE_W = 3;

    spawn_state_t         state, state_n;
    logic [SLOT_BITS-1:0] cand, cand_n;
    logic [SLOT_BITS-1:0] tries, tries_n;
    logic [SLOT_BITS-1:0] slot_n;
    logic [COORD_W-1:0]   x_n, y_n;
    logic [LEFT_W-1:0]    left_n;
    logic [ALIVE_W-1:0]   alive_n;
    logic                 valid_n, rise_n;
    logic                 xfer;
    logic                 tmr_load, tmr_dec, tmr_zero;
    logic [TIMER_W-1:0]   tmr_value;
    spawn_coord_t         cand_coord;

    assign cand_coord    = slot_coord(SLOT_IDX_W'(cand));
    assign tmr_dec       = (state == WAIT) && startOfFrame;
    assign level_cleared = game_enable && (enemies_left == '0) && (alive_cnt == '0);

    frame_down_timer u_timer (
        .clk        (clk),
        .resetN     (resetN),
        .load       (tmr_load),
        .load_value (tmr_value),
        .dec        (tmr_dec),
        .zero       (tmr_zero)
    );

    // Next-state, counter and offer-payload logic.
    always_comb begin
        state_n   = state;
        cand_n    = cand;
        tries_n   = tries;
        slot_n    = spawn_slot;
        x_n       = spawn_x;
        y_n       = spawn_y;
        left_n    = enemies_left;
        alive_n   = alive_cnt;
        tmr_load  = 1'b0;
        tmr_value = TIMER_W'(SPAWN_PERIOD);
        xfer      = 1'b0;

        if (!game_enable) begin
            state_n = IDLE;
            left_n  = LEFT_W'(TOTAL_ENEMIES);
            alive_n = '0;
        end else begin
            case (state)
                IDLE: begin
                    tmr_load = 1'b1;
                    state_n  = WAIT;
                end
                WAIT: begin
                    if (tmr_zero) begin
                        if (enemies_left == '0) begin
                            state_n = DONE;
                        end else if (alive_cnt == ALIVE_W'(MAX_ALIVE)) begin
                            tmr_load  = 1'b1;
                            tmr_value = TIMER_W'(RETRY_FRAMES);
                        end else begin
                            state_n = REQ;
                        end
                    end
                end
                REQ: begin
                    state_n = SAMPLE;
                end
                SAMPLE: begin
                    cand_n  = rand_slot;
                    tries_n = '0;
                    state_n = CHECK;
                end
                CHECK: begin
                    if (!slot_blocked[cand]) begin
                        slot_n  = cand;
                        x_n     = cand_coord.x;
                        y_n     = cand_coord.y;
                        state_n = OFFER;
                    end else if (tries == SLOT_BITS'(NUM_SLOTS - 1)) begin
                        tmr_load  = 1'b1;
                        tmr_value = TIMER_W'(RETRY_FRAMES);
                        state_n   = WAIT;
                    end else begin
                        cand_n  = cand + SLOT_BITS'(1);
                        tries_n = tries + SLOT_BITS'(1);
                    end
                end
                OFFER: begin
                    if (spawn_ready) begin
                        xfer     = 1'b1;
                        left_n   = enemies_left - LEFT_W'(1);
                        alive_n  = alive_cnt + ALIVE_W'(1);
                        tmr_load = 1'b1;
                        state_n  = WAIT;
                    end
                end
                DONE: begin
                    state_n = DONE;
                end
                default: begin
                    state_n = IDLE;
                end
            endcase

            // A death in the same cycle as a transfer cancels the increment.
            if (enemy_destroyed) begin
                if (xfer) begin
                    alive_n = alive_cnt;
                end else if (alive_cnt != '0) begin
                    alive_n = alive_cnt - ALIVE_W'(1);
                end
            end
        end

        valid_n = (state_n == OFFER);
        rise_n  = (state_n == REQ);
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state        <= IDLE;
            cand         <= '0;
            tries        <= '0;
            spawn_slot   <= '0;
            spawn_x      <= '0;
            spawn_y      <= '0;
            enemies_left <= LEFT_W'(TOTAL_ENEMIES);
            alive_cnt    <= '0;
            spawn_valid  <= 1'b0;
            rand_rise    <= 1'b0;
        end else begin
            state        <= state_n;
            cand         <= cand_n;
            tries        <= tries_n;
            spawn_slot   <= slot_n;
            spawn_x      <= x_n;
            spawn_y      <= y_n;
            enemies_left <= left_n;
            alive_cnt    <= alive_n;
            spawn_valid  <= valid_n;
            rand_rise    <= rise_n;
        end
    end

endmodule

// File: tb/tb_enemy_spawn_ctrl.sv
// Self-checking bench for enemy_spawn_ctrl: directed scenarios plus a
// randomized run, checked against a transaction-level model of spawns.
`timescale 1ns/1ps
module tb_enemy_spawn_ctrl;

    localparam int unsigned SP = 2;
    localparam int unsigned RF = 3;
    localparam int unsigned TE = 6;
    localparam int unsigned MA = 4;

    logic        clk = 1'b0;
    logic        resetN = 1'b0;
    logic        game_enable = 1'b0;
    logic        startOfFrame = 1'b0;
    logic [1:0]  rand_slot = '0;
    logic [3:0]  slot_blocked = '0;
    logic        enemy_destroyed = 1'b0;
    logic        spawn_ready = 1'b0;
    logic        rand_rise;
    logic        spawn_valid;
    logic [1:0]  spawn_slot;
    logic [10:0] spawn_x;
    logic [10:0] spawn_y;
    logic [4:0]  enemies_left;
    logic [2:0]  alive_cnt;
    logic        level_cleared;

    int checks = 0;
    int errors = 0;
    int m_left = TE;
    int m_alive = 0;
    int cyc = 0, rise_cnt = 0, valid_cnt = 0, rise_cyc = 0, valid_cyc = 0;
    logic rr_last = 1'b0;
    logic sv_prev = 1'b0;
    logic [1:0] want_slot = '0;

    enemy_spawn_ctrl #(
        .SPAWN_PERIOD (SP),
        .RETRY_FRAMES (RF),
        .TOTAL_ENEMIES(TE),
        .MAX_ALIVE    (MA),
        .NUM_SLOTS    (4),
        .SLOT_BITS    (2)
    ) dut (
        .clk            (clk),
        .resetN         (resetN),
        .game_enable    (game_enable),
        .startOfFrame   (startOfFrame),
        .rand_slot      (rand_slot),
        .slot_blocked   (slot_blocked),
        .enemy_destroyed(enemy_destroyed),
        .spawn_ready    (spawn_ready),
        .rand_rise      (rand_rise),
        .spawn_valid    (spawn_valid),
        .spawn_slot     (spawn_slot),
        .spawn_x        (spawn_x),
        .spawn_y        (spawn_y),
        .enemies_left   (enemies_left),
        .alive_cnt      (alive_cnt),
        .level_cleared  (level_cleared)
    );

    initial forever #5 clk = ~clk;

    // Event monitor on the falling edge: rand_rise pulses and spawn_valid rises.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            rr_last = rand_rise;
            if (rand_rise) begin rise_cnt++; rise_cyc = cyc; end
            if (spawn_valid && !sv_prev) begin valid_cnt++; valid_cyc = cyc; end
            sv_prev = spawn_valid;
        end
    end

    // Random generator stand-in: the wanted slot only in the cycle after rand_rise.
    initial begin
        forever begin
            @(posedge clk); #1;
            rand_slot = rr_last ? want_slot : 2'($urandom);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic frame();
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0;
        repeat (3) tick();
    endtask

    task automatic destroy_one();
        enemy_destroyed = 1'b1;
        tick();
        enemy_destroyed = 1'b0;
        if (m_alive > 0) m_alive--;
    endtask

    task automatic accept(input bit with_destroy);
        spawn_ready = 1'b1;
        enemy_destroyed = with_destroy;
        tick();
        spawn_ready = 1'b0;
        enemy_destroyed = 1'b0;
        m_left--;
        if (!with_destroy) m_alive++;
    endtask

    // First free slot scanning upward from r with wraparound; -1 if none.
    function automatic int pick_slot(input int r, input logic [3:0] blk, output int misses);
        misses = 0;
        for (int k = 0; k < 4; k++) begin
            if (!blk[(r + k) % 4]) return (r + k) % 4;
            misses++;
        end
        return -1;
    endfunction

    // Sends frames until a spawn attempt fires; reports rises seen before the
    // final frame, total rises, and rise-to-valid latency (-1 if no offer).
    task automatic trigger(input int frames, input int r, input logic [3:0] blk,
                           output int early, output int rises, output int lat);
        int r0, v0;
        want_slot = 2'(r);
        slot_blocked = blk;
        r0 = rise_cnt;
        v0 = valid_cnt;
        for (int f = 0; f < frames - 1; f++) frame();
        early = rise_cnt - r0;
        frame();
        for (int i = 0; i < 16 && valid_cnt == v0; i++) tick();
        rises = rise_cnt - r0;
        lat = (valid_cnt != v0) ? (valid_cyc - rise_cyc) : -1;
    endtask

    task automatic test_reset();
        resetN = 1'b0;
        repeat (3) tick();
        checks++; if (rand_rise !== 1'b0) begin errors++; $display("FAIL reset_rise: got %b expected 0", rand_rise); end
        checks++; if (spawn_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", spawn_valid); end
        checks++; if (spawn_slot !== 2'd0) begin errors++; $display("FAIL reset_slot: got %0d expected 0", spawn_slot); end
        checks++; if (spawn_x !== 11'd0 || spawn_y !== 11'd0) begin errors++; $display("FAIL reset_xy: got %0d,%0d expected 0,0", spawn_x, spawn_y); end
        checks++; if (enemies_left !== 5'(TE)) begin errors++; $display("FAIL reset_left: got %0d expected %0d", enemies_left, TE); end
        checks++; if (alive_cnt !== 3'd0) begin errors++; $display("FAIL reset_alive: got %0d expected 0", alive_cnt); end
        checks++; if (level_cleared !== 1'b0) begin errors++; $display("FAIL reset_cleared: got %b expected 0", level_cleared); end
        resetN = 1'b1;
        tick();
        m_left = TE;
        m_alive = 0;
    endtask

    task automatic test_basic_spawn();
        int early, rises, lat;
        game_enable = 1'b1;
        tick();
        trigger(SP, 2, 4'b0000, early, rises, lat);
        checks++; if (early !== 0) begin errors++; $display("FAIL basic_early_rise: got %0d expected 0", early); end
        checks++; if (rises !== 1) begin errors++; $display("FAIL basic_rise_count: got %0d expected 1", rises); end
        checks++; if (lat !== 3) begin errors++; $display("FAIL basic_latency: got %0d expected 3", lat); end
        checks++; if (spawn_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b expected 1", spawn_valid); end
        checks++; if (spawn_slot !== 2'd2) begin errors++; $display("FAIL basic_slot: got %0d expected 2", spawn_slot); end
        checks++; if (spawn_x !== 11'd352 || spawn_y !== 11'd32) begin errors++; $display("FAIL basic_xy: got %0d,%0d expected 352,32", spawn_x, spawn_y); end
        accept(1'b0);
        checks++; if (spawn_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_drop: got %b expected 0", spawn_valid); end
        checks++; if (enemies_left !== 5'(m_left)) begin errors++; $display("FAIL basic_left: got %0d expected %0d", enemies_left, m_left); end
        checks++; if (alive_cnt !== 3'(m_alive)) begin errors++; $display("FAIL basic_alive: got %0d expected %0d", alive_cnt, m_alive); end
    endtask

    task automatic test_wrap();
        int early, rises, lat;
        trigger(SP, 3, 4'b1001, early, rises, lat);
        checks++; if (lat !== 5) begin errors++; $display("FAIL wrap_latency: got %0d expected 5", lat); end
        checks++; if (spawn_slot !== 2'd1) begin errors++; $display("FAIL wrap_slot: got %0d expected 1", spawn_slot); end
        checks++; if (spawn_x !== 11'd192 || spawn_y !== 11'd32) begin errors++; $display("FAIL wrap_xy: got %0d,%0d expected 192,32", spawn_x, spawn_y); end
        accept(1'b0);
        checks++; if (enemies_left !== 5'(m_left) || alive_cnt !== 3'(m_alive)) begin errors++; $display("FAIL wrap_counters: got %0d/%0d expected %0d/%0d", enemies_left, alive_cnt, m_left, m_alive); end
    endtask

    task automatic test_all_blocked();
        int early, rises, lat, r, p, miss;
        r = int'($urandom_range(3, 0));
        trigger(SP, r, 4'b1111, early, rises, lat);
        checks++; if (rises !== 1) begin errors++; $display("FAIL blocked_rise_count: got %0d expected 1", rises); end
        checks++; if (lat !== -1 || spawn_valid !== 1'b0) begin errors++; $display("FAIL blocked_no_offer: got lat %0d valid %b expected -1, 0", lat, spawn_valid); end
        checks++; if (enemies_left !== 5'(m_left)) begin errors++; $display("FAIL blocked_left: got %0d expected %0d", enemies_left, m_left); end
        r = int'($urandom_range(3, 0));
        p = pick_slot(r, 4'b0000, miss);
        trigger(RF, r, 4'b0000, early, rises, lat);
        checks++; if (early !== 0) begin errors++; $display("FAIL retry_early_rise: got %0d expected 0", early); end
        checks++; if (rises !== 1) begin errors++; $display("FAIL retry_rise_count: got %0d expected 1", rises); end
        checks++; if (spawn_slot !== 2'(p)) begin errors++; $display("FAIL retry_slot: got %0d expected %0d", spawn_slot, p); end
        accept(1'b0);
    endtask

    task automatic test_destroy_on_transfer();
        int early, rises, lat, r, p, miss;
        logic [3:0] blk;
        r = int'($urandom_range(3, 0));
        blk = 4'($urandom) & 4'b0111;
        p = pick_slot(r, blk, miss);
        trigger(SP, r, blk, early, rises, lat);
        checks++; if (spawn_slot !== 2'(p) || lat !== 3 + miss) begin errors++; $display("FAIL coinc_offer: got slot %0d lat %0d expected %0d, %0d", spawn_slot, lat, p, 3 + miss); end
        accept(1'b1);
        checks++; if (alive_cnt !== 3'(m_alive)) begin errors++; $display("FAIL coinc_alive: got %0d expected %0d", alive_cnt, m_alive); end
        checks++; if (enemies_left !== 5'(m_left)) begin errors++; $display("FAIL coinc_left: got %0d expected %0d", enemies_left, m_left); end
        trigger(SP, r, 4'b0000, early, rises, lat);
        accept(1'b0);
        checks++; if (alive_cnt !== 3'(MA)) begin errors++; $display("FAIL cap_reach: got %0d expected %0d", alive_cnt, MA); end
    endtask

    task automatic test_alive_cap();
        int r0, early, rises, lat;
        r0 = rise_cnt;
        for (int f = 0; f < int'(SP + 2 * RF); f++) frame();
        checks++; if (rise_cnt !== r0 || spawn_valid !== 1'b0) begin errors++; $display("FAIL cap_no_attempt: got %0d rises valid %b expected 0, 0", rise_cnt - r0, spawn_valid); end
        destroy_one();
        checks++; if (alive_cnt !== 3'(m_alive)) begin errors++; $display("FAIL cap_destroy: got %0d expected %0d", alive_cnt, m_alive); end
        trigger(RF, 0, 4'b0000, early, rises, lat);
        checks++; if (early !== 0 || rises !== 1) begin errors++; $display("FAIL cap_retry_rise: got early %0d rises %0d expected 0, 1", early, rises); end
        checks++; if (spawn_slot !== 2'd0 || spawn_x !== 11'd32) begin errors++; $display("FAIL cap_retry_slot: got %0d x %0d expected 0, 32", spawn_slot, spawn_x); end
        accept(1'b0);
        checks++; if (enemies_left !== 5'(m_left) || alive_cnt !== 3'(m_alive)) begin errors++; $display("FAIL cap_counters: got %0d/%0d expected %0d/%0d", enemies_left, alive_cnt, m_left, m_alive); end
    endtask

    task automatic test_done();
        int r0;
        r0 = rise_cnt;
        for (int f = 0; f < int'(SP + 4); f++) frame();
        checks++; if (rise_cnt !== r0) begin errors++; $display("FAIL done_no_rise: got %0d rises expected 0", rise_cnt - r0); end
        checks++; if (level_cleared !== 1'(m_left == 0 && m_alive == 0)) begin errors++; $display("FAIL done_not_cleared: got %b expected %b", level_cleared, (m_left == 0 && m_alive == 0)); end
        enemy_destroyed = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (m_alive > 0) m_alive--;
            checks++; if (alive_cnt !== 3'(m_alive)) begin errors++; $display("FAIL done_destroy_%0d: got %0d expected %0d", i, alive_cnt, m_alive); end
        end
        enemy_destroyed = 1'b0;
        checks++; if (level_cleared !== 1'b1) begin errors++; $display("FAIL done_cleared: got %b expected 1", level_cleared); end
        for (int f = 0; f < 3; f++) frame();
        checks++; if (rise_cnt !== r0 || spawn_valid !== 1'b0) begin errors++; $display("FAIL done_idle: got %0d rises valid %b expected 0, 0", rise_cnt - r0, spawn_valid); end
    endtask

    task automatic test_ready_stall();
        int early, rises, lat, r, p, miss;
        logic [3:0] blk;
        game_enable = 1'b0;
        tick();
        checks++; if (enemies_left !== 5'(TE) || alive_cnt !== 3'd0) begin errors++; $display("FAIL restart_counters: got %0d/%0d expected %0d/0", enemies_left, alive_cnt, TE); end
        game_enable = 1'b1;
        tick();
        m_left = TE;
        m_alive = 0;
        trigger(SP, 1, 4'b0000, early, rises, lat);
        accept(1'b0);
        r = int'($urandom_range(3, 0));
        blk = 4'($urandom) & 4'b1110;
        p = pick_slot(r, blk, miss);
        trigger(SP, r, blk, early, rises, lat);
        for (int i = 0; i < 10; i++) begin
            slot_blocked = 4'($urandom);
            tick();
            checks++;
            if (spawn_valid !== 1'b1 || spawn_slot !== 2'(p) || spawn_x !== 11'(32 + 160 * p)) begin
                errors++;
                $display("FAIL stall_hold_%0d: got valid %b slot %0d x %0d expected 1, %0d, %0d", i, spawn_valid, spawn_slot, spawn_x, p, 32 + 160 * p);
            end
        end
        game_enable = 1'b0;
        tick();
        checks++; if (spawn_valid !== 1'b0) begin errors++; $display("FAIL abort_valid: got %b expected 0", spawn_valid); end
        checks++; if (enemies_left !== 5'(TE) || alive_cnt !== 3'd0) begin errors++; $display("FAIL abort_counters: got %0d/%0d expected %0d/0", enemies_left, alive_cnt, TE); end
        m_left = TE;
        m_alive = 0;
    endtask

    task automatic test_async_reset();
        int early, rises, lat;
        game_enable = 1'b1;
        tick();
        trigger(SP, 3, 4'b0000, early, rises, lat);
        accept(1'b0);
        trigger(SP, 2, 4'b0000, early, rises, lat);
        checks++; if (spawn_valid !== 1'b1) begin errors++; $display("FAIL areset_pre_valid: got %b expected 1", spawn_valid); end
        #2;
        resetN = 1'b0;
        #1;
        checks++; if (spawn_valid !== 1'b0 || rand_rise !== 1'b0) begin errors++; $display("FAIL areset_handshake: got valid %b rise %b expected 0, 0", spawn_valid, rand_rise); end
        checks++; if (spawn_slot !== 2'd0 || spawn_x !== 11'd0 || spawn_y !== 11'd0) begin errors++; $display("FAIL areset_payload: got %0d %0d %0d expected 0 0 0", spawn_slot, spawn_x, spawn_y); end
        checks++; if (enemies_left !== 5'(TE) || alive_cnt !== 3'd0) begin errors++; $display("FAIL areset_counters: got %0d/%0d expected %0d/0", enemies_left, alive_cnt, TE); end
        tick();
        resetN = 1'b1;
        tick();
        m_left = TE;
        m_alive = 0;
    endtask

    task automatic test_random();
        int early, rises, lat, r, p, miss, frames;
        logic [3:0] blk;
        bit wd;
        frames = SP;
        for (int it = 0; it < 30 && m_left > 0; it++) begin
            if (m_alive == int'(MA) || $urandom_range(2, 0) == 0) destroy_one();
            r = int'($urandom_range(3, 0));
            blk = 4'($urandom);
            p = pick_slot(r, blk, miss);
            trigger(frames, r, blk, early, rises, lat);
            checks++; if (early !== 0 || rises !== 1) begin errors++; $display("FAIL rnd_rise_%0d: got early %0d rises %0d expected 0, 1", it, early, rises); end
            if (p >= 0) begin
                checks++;
                if (lat !== 3 + miss || spawn_slot !== 2'(p) || spawn_x !== 11'(32 + 160 * p) || spawn_y !== 11'd32) begin
                    errors++;
                    $display("FAIL rnd_offer_%0d: got lat %0d slot %0d x %0d y %0d expected %0d %0d %0d 32", it, lat, spawn_slot, spawn_x, spawn_y, 3 + miss, p, 32 + 160 * p);
                end
                wd = 1'($urandom_range(1, 0));
                accept(wd);
                frames = SP;
            end else begin
                checks++; if (lat !== -1 || spawn_valid !== 1'b0) begin errors++; $display("FAIL rnd_blocked_%0d: got lat %0d valid %b expected -1, 0", it, lat, spawn_valid); end
                frames = RF;
            end
            checks++;
            if (enemies_left !== 5'(m_left) || alive_cnt !== 3'(m_alive)) begin
                errors++;
                $display("FAIL rnd_counters_%0d: got %0d/%0d expected %0d/%0d", it, enemies_left, alive_cnt, m_left, m_alive);
            end
        end
        checks++; if (level_cleared !== 1'(m_left == 0 && m_alive == 0)) begin errors++; $display("FAIL rnd_cleared: got %b expected %b", level_cleared, (m_left == 0 && m_alive == 0)); end
    endtask

    initial begin
        test_reset();
        test_basic_spawn();
        test_wrap();
        test_all_blocked();
        test_destroy_on_transfer();
        test_alive_cap();
        test_done();
        test_ready_stall();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
